// File: rtl/ascon_aead_seq.sv
// ascon_aead_seq: ASCON-128 encryption sequencer driving an external single-round permutation core.
// Holds the 320-bit state and steps one round per clock through init, AD, plaintext and finalization.
module ascon_aead_seq #(
    parameter logic [63:0] IV       = 64'h80400C0600000000,
    parameter int          A_ROUNDS = 12,
    parameter int          B_ROUNDS = 6,
    parameter int          CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [127:0]     nonce,
    input  logic [CNT_W-1:0] ad_cnt,
    input  logic [CNT_W-1:0] pt_cnt,
    input  logic             ad_valid,
    input  logic [63:0]      ad_data,
    output logic             ad_ready,
    input  logic             pt_valid,
    input  logic [63:0]      pt_data,
    output logic             pt_ready,
    output logic             ct_valid,
    output logic [63:0]      ct_data,
    output logic [127:0]     tag,
    output logic             done,
    output logic             busy,
    output logic [319:0]     perm_state_o,
    output logic [3:0]       perm_round_o,
    input  logic [319:0]     perm_state_i
);
    localparam logic [3:0] R_LAST = 4'(A_ROUNDS - 1);
    localparam logic [3:0] R_B    = 4'(A_ROUNDS - B_ROUNDS);

    typedef enum logic [2:0] {IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL} state_t;

    state_t             state, state_n;
    logic [319:0]       x, x_n;
    logic [127:0]       key_q, key_n, tag_n;
    logic [CNT_W-1:0]   ad_left, ad_n, pt_left, pt_n;
    logic [3:0]         r, r_n;
    logic [63:0]        ct_n;
    logic               ct_v_n, done_n, last, ad_end;

    assign ad_ready     = state == AD_WAIT;
    assign pt_ready     = state == PT_WAIT;
    assign busy         = state != IDLE;
    assign perm_state_o = x;
    assign perm_round_o = r;
    assign last         = r == R_LAST;
    assign ad_end       = ad_left == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            key_q    <= '0;
            ad_left  <= '0;
            pt_left  <= '0;
            r        <= '0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
            tag      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            key_q    <= key_n;
            ad_left  <= ad_n;
            pt_left  <= pt_n;
            r        <= r_n;
            ct_valid <= ct_v_n;
            ct_data  <= ct_n;
            tag      <= tag_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        key_n   = key_q;
        ad_n    = ad_left;
        pt_n    = pt_left;
        r_n     = r;
        ct_v_n  = 1'b0;
        ct_n    = ct_data;
        tag_n   = tag;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start && pt_cnt != '0) begin
                x_n     = {IV, key, nonce};
                key_n   = key;
                ad_n    = ad_cnt;
                pt_n    = pt_cnt;
                r_n     = '0;
                state_n = INIT;
            end
            INIT: begin
                x_n = perm_state_i;
                r_n = r + 4'd1;
                if (last) begin
                    // key mix-in, plus domain separation when there is no AD at all
                    x_n[127:0] = perm_state_i[127:0] ^ key_q ^ {127'd0, ad_end};
                    r_n        = '0;
                    state_n    = ad_end ? PT_WAIT : AD_WAIT;
                end
            end
            AD_WAIT: if (ad_valid) begin
                x_n[319:256] = x[319:256] ^ ad_data;
                ad_n         = ad_left - CNT_W'(1);
                r_n          = R_B;
                state_n      = AD_PERM;
            end
            AD_PERM: begin
                x_n = perm_state_i;
                r_n = r + 4'd1;
                if (last) begin
                    x_n[0]  = perm_state_i[0] ^ ad_end;
                    r_n     = '0;
                    state_n = ad_end ? PT_WAIT : AD_WAIT;
                end
            end
            PT_WAIT: if (pt_valid) begin
                x_n[319:256] = x[319:256] ^ pt_data;
                ct_v_n       = 1'b1;
                ct_n         = x[319:256] ^ pt_data;
                pt_n         = pt_left - CNT_W'(1);
                r_n          = R_B;
                state_n      = PT_PERM;
                if (pt_left == CNT_W'(1)) begin
                    x_n[255:128] = x[255:128] ^ key_q;
                    r_n          = '0;
                    state_n      = FINAL;
                end
            end
            PT_PERM: begin
                x_n     = perm_state_i;
                r_n     = last ? 4'd0 : r + 4'd1;
                state_n = last ? PT_WAIT : PT_PERM;
            end
            FINAL: begin
                x_n = perm_state_i;
                r_n = r + 4'd1;
                if (last) begin
                    tag_n   = perm_state_i[127:0] ^ key_q;
                    done_n  = 1'b1;
                    r_n     = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ascon_aead_seq.sv
// tb_ascon_aead_seq: randomized self-checking bench for ascon_aead_seq.
// Supplies the ASCON round core and compares against an algorithm-level ASCON-128 model.
module tb_ascon_aead_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0, nonce = '0;
    logic [3:0]   ad_cnt = '0, pt_cnt = '0;
    logic         ad_valid = 1'b0, pt_valid = 1'b0;
    logic [63:0]  ad_data = '0, pt_data = '0;
    logic         ad_ready, pt_ready, ct_valid, done, busy;
    logic [63:0]  ct_data;
    logic [127:0] tag;
    logic [319:0] perm_state_o, perm_state_i;
    logic [3:0]   perm_round_o;

    int n_cmp = 0, n_fail = 0;
    logic [63:0]  ad_q [0:15];
    logic [63:0]  pt_q [0:15];
    logic [63:0]  exp_ct [0:15];
    logic [63:0]  ct_got [0:15];
    int           ct_edge [0:15];
    logic [127:0] exp_tag, tag_got;
    int           nct, done_edge, ad_hs, ad_rdy_seen, round_moves;

    ascon_aead_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .ad_cnt(ad_cnt), .pt_cnt(pt_cnt),
        .ad_valid(ad_valid), .ad_data(ad_data), .ad_ready(ad_ready),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .ct_valid(ct_valid), .ct_data(ct_data), .tag(tag), .done(done), .busy(busy),
        .perm_state_o(perm_state_o), .perm_round_o(perm_round_o), .perm_state_i(perm_state_i)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] rnd(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 ^= {56'd0, 4'hF - r, r};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= ror(x0, 19) ^ ror(x0, 28);
        x1 ^= ror(x1, 61) ^ ror(x1, 39);
        x2 ^= ror(x2, 1) ^ ror(x2, 6);
        x3 ^= ror(x3, 10) ^ ror(x3, 17);
        x4 ^= ror(x4, 7) ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb perm_state_i = rnd(perm_state_o, perm_round_o);

    function automatic logic [319:0] perm(input logic [319:0] s, input int rounds);
        for (int i = 12 - rounds; i < 12; i++) s = rnd(s, 4'(i));
        return s;
    endfunction

    // ASCON-128 encryption over caller-padded full blocks
    function automatic void model(input logic [127:0] k, input logic [127:0] n, input int na, input int np);
        logic [319:0] s;
        s = perm({64'h80400C0600000000, k, n}, 12);
        s[127:0] ^= k;
        for (int i = 0; i < na; i++) begin
            s[319:256] ^= ad_q[i];
            s = perm(s, 6);
        end
        s[0] ^= 1'b1;
        for (int i = 0; i < np; i++) begin
            s[319:256] ^= pt_q[i];
            exp_ct[i] = s[319:256];
            if (i < np - 1) s = perm(s, 6);
        end
        s[255:128] ^= k;
        s = perm(s, 12);
        exp_tag = s[127:0] ^ k;
    endfunction

    // Streams one message with valid/ready handshakes; edge 0 is the start edge
    task automatic run_msg(input logic [127:0] k, input logic [127:0] n, input int na, input int np,
                           input int gap_at, input int gap_len, input bit final_start);
        int e, ai, pi, gap, fin;
        bit hs_a, hs_p, gapping;
        logic [3:0] prev_round;
        nct = 0; done_edge = -1; ad_hs = 0; ad_rdy_seen = 0; round_moves = 0;
        ai = 0; pi = 0; gap = 0; fin = -1; e = -1;
        start = 1'b1; key = k; nonce = n; ad_cnt = 4'(na); pt_cnt = 4'(np);
        ad_data = ad_q[0]; pt_data = pt_q[0]; pt_valid = 1'b1;
        while (done_edge < 0 && e < 400) begin
            gapping = ai == gap_at && gap < gap_len && ad_ready;
            ad_valid = !gapping;
            if (gapping) gap++;
            hs_a = ad_ready && ad_valid;
            hs_p = pt_ready && pt_valid;
            if (ad_ready) ad_rdy_seen++;
            prev_round = perm_round_o;
            @(posedge clk); #1; e++;
            start = 1'b0;
            if (gapping && perm_round_o !== prev_round) round_moves++;
            if (hs_a) begin ai++; ad_hs++; ad_data = ad_q[ai]; end
            if (hs_p) begin pi++; pt_data = pt_q[pi]; end
            if (ct_valid) begin ct_got[nct] = ct_data; ct_edge[nct] = e; nct++; end
            if (final_start && pi == np) fin++;
            if (fin == 3) begin start = 1'b1; key = ~k; pt_cnt = 4'd1; end
            if (done) begin done_edge = e; tag_got = tag; end
        end
        ad_valid = 1'b0; pt_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ad_ready, pt_ready, ct_valid, done, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 00000", {ad_ready, pt_ready, ct_valid, done, busy});
        end
        n_cmp++;
        if ({ct_data, tag, perm_round_o} !== '0) begin
            n_fail++; $display("FAIL reset_data got ct=%h tag=%h r=%0d exp 0", ct_data, tag, perm_round_o);
        end
    endtask

    task automatic check_msg(input string nm, input int na, input int np, input int extra);
        n_cmp++;
        if (done_edge !== 25 + 7 * na + 7 * (np - 1) + extra) begin
            n_fail++; $display("FAIL %s done_edge got %0d exp %0d", nm, done_edge, 25 + 7 * na + 7 * (np - 1) + extra);
        end
        n_cmp++;
        if (nct !== np) begin n_fail++; $display("FAIL %s ct_count got %0d exp %0d", nm, nct, np); end
        for (int i = 0; i < np && i < nct; i++) begin
            n_cmp++;
            if (ct_got[i] !== exp_ct[i]) begin
                n_fail++; $display("FAIL %s ct[%0d] got %h exp %h", nm, i, ct_got[i], exp_ct[i]);
            end
        end
        n_cmp++;
        if (tag_got !== exp_tag) begin n_fail++; $display("FAIL %s tag got %h exp %h", nm, tag_got, exp_tag); end
    endtask

    task automatic test_full_message;
        logic [127:0] k, n;
        k = {64'h265F1C12888E151A, 64'hC74F26B30A8C44B2};
        n = {64'h369C801F3AE8D0EA, 64'h9BF367D58FD211FF};
        ad_q[0] = 64'h7895160; ad_q[1] = 64'h8882055; ad_q[2] = 64'h37008;
        pt_q[0] = 64'h1234567890abcdef; pt_q[1] = 64'h1234567890abcdef;
        model(k, n, 3, 2);
        @(posedge clk); #1;
        run_msg(k, n, 3, 2, -1, 0, 1'b0);
        check_msg("full", 3, 2, 0);
        n_cmp++;
        if (ct_edge[0] !== 34 || ct_edge[1] !== 41) begin
            n_fail++; $display("FAIL full ct_edges got %0d,%0d exp 34,41", ct_edge[0], ct_edge[1]);
        end
    endtask

    task automatic test_no_ad;
        logic [127:0] k, n;
        k = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        pt_q[0] = {$urandom, $urandom};
        model(k, n, 0, 1);
        @(posedge clk); #1;
        run_msg(k, n, 0, 1, -1, 0, 1'b0);
        check_msg("no_ad", 0, 1, 0);
        n_cmp++;
        if (ad_rdy_seen !== 0) begin n_fail++; $display("FAIL no_ad ad_ready_cycles got %0d exp 0", ad_rdy_seen); end
    endtask

    task automatic test_random;
        logic [127:0] k, n;
        int na, np;
        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            n = {$urandom, $urandom, $urandom, $urandom};
            na = int'($urandom_range(0, 4));
            np = int'($urandom_range(1, 4));
            for (int i = 0; i < 16; i++) begin ad_q[i] = {$urandom, $urandom}; pt_q[i] = {$urandom, $urandom}; end
            model(k, n, na, np);
            @(posedge clk); #1;
            run_msg(k, n, na, np, -1, 0, 1'b0);
            check_msg("random", na, np, 0);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] k, n;
        k = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin ad_q[i] = {$urandom, $urandom}; pt_q[i] = {$urandom, $urandom}; end
        model(k, n, 2, 2);
        run_msg(k, n, 2, 2, -1, 0, 1'b0);
        check_msg("b2b_a", 2, 2, 0);
        run_msg(k, n, 2, 2, -1, 0, 1'b0);
        check_msg("b2b_b", 2, 2, 0);
    endtask

    task automatic test_backpressure;
        logic [127:0] k, n;
        k = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin ad_q[i] = {$urandom, $urandom}; pt_q[i] = {$urandom, $urandom}; end
        model(k, n, 3, 2);
        @(posedge clk); #1;
        run_msg(k, n, 3, 2, 1, 5, 1'b0);
        check_msg("backpressure", 3, 2, 5);
        n_cmp++;
        if (round_moves !== 0) begin n_fail++; $display("FAIL backpressure round_moves got %0d exp 0", round_moves); end
        n_cmp++;
        if (ad_hs !== 3) begin n_fail++; $display("FAIL backpressure ad_handshakes got %0d exp 3", ad_hs); end
    endtask

    task automatic test_illegal_start;
        logic [127:0] k, n;
        @(posedge clk); #1;
        start = 1'b1; pt_cnt = 4'd0; ad_cnt = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || perm_round_o !== 4'd0) begin
            n_fail++; $display("FAIL pt0_start busy=%b r=%0d exp busy=0 r=0", busy, perm_round_o);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin ad_q[i] = {$urandom, $urandom}; pt_q[i] = {$urandom, $urandom}; end
        model(k, n, 1, 2);
        run_msg(k, n, 1, 2, -1, 0, 1'b1);
        check_msg("final_start", 1, 2, 0);
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL final_start busy_after got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [127:0] k, n;
        bit seen;
        int c;
        k = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin ad_q[i] = {$urandom, $urandom}; pt_q[i] = {$urandom, $urandom}; end
        model(k, n, 2, 1);
        @(posedge clk); #1;
        start = 1'b1; key = k; nonce = n; ad_cnt = 4'd2; pt_cnt = 4'd1;
        ad_valid = 1'b1; ad_data = ad_q[0]; seen = 1'b0; c = 0;
        while (!(seen && perm_round_o == 4'd8) && c < 100) begin
            if (ad_ready) seen = 1'b1;
            @(posedge clk); #1; c++;
            start = 1'b0;
        end
        ad_valid = 1'b0;
        n_cmp++;
        if (c >= 100) begin n_fail++; $display("FAIL reset_mid reach_r8 got timeout exp AD_PERM r=8"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ad_ready, pt_ready, ct_valid, done, busy} !== 5'b0 || {ct_data, tag, perm_round_o} !== '0) begin
            n_fail++; $display("FAIL reset_mid outputs got flags=%b r=%0d tag=%h exp all 0",
                               {ad_ready, pt_ready, ct_valid, done, busy}, perm_round_o, tag);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({ct_valid, done, busy} !== 3'b0) begin
            n_fail++; $display("FAIL reset_mid after_release got %b exp 000", {ct_valid, done, busy});
        end
        run_msg(k, n, 2, 1, -1, 0, 1'b0);
        check_msg("reset_mid_rerun", 2, 1, 0);
    endtask

    initial begin
        test_reset;
        test_full_message;
        test_no_ad;
        test_random;
        test_back_to_back;
        test_backpressure;
        test_illegal_start;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ascon_aead_seq.md
Name: ascon_aead_seq

Overview:
- Sequencer for ASCON-128 authenticated encryption. Owns the 320-bit state register (x0..x4) and an FSM that steps an external single-round permutation core, one round per clock.
- Streams associated data (AD) and plaintext in 64-bit rate blocks and emits ciphertext blocks and the 128-bit tag.
- Sits between the top-level `demo` datapath wrapper and the combinational round core, so one round core serves the init, AD, plaintext and finalization phases.

Parameters:
- `IV`, 64'h80400C0600000000, ASCON-128 initialization word, loaded into x0.
- `A_ROUNDS`, 12, rounds for initialization and finalization (p^a).
- `B_ROUNDS`, 6, rounds per rate block (p^b).
- `CNT_W`, 4, width of the block-count inputs.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a message; sampled only in IDLE.
- `key` in 128: {k0,k1}, k0 in [127:64]; sampled at start.
- `nonce` in 128: {n0,n1}; sampled at start.
- `ad_cnt` in CNT_W: number of AD blocks, 0 allowed; sampled at start.
- `pt_cnt` in CNT_W: number of plaintext blocks, must be ≥1; sampled at start.
- `ad_valid` in 1, `ad_data` in 64, `ad_ready` out 1: AD stream; blocks arrive caller-padded.
- `pt_valid` in 1, `pt_data` in 64, `pt_ready` out 1: plaintext stream; last block arrives caller-padded.
- `ct_valid` out 1, `ct_data` out 64: ciphertext block, one-cycle pulse, no backpressure.
- `tag` out 128: {x3^k0, x4^k1}.
- `done` out 1: one-cycle pulse; `tag` is valid while high.
- `busy` out 1: high in any state other than IDLE.
- `perm_state_o` out 320: current {x0,x1,x2,x3,x4} to the round core.
- `perm_round_o` out 4: round index r, 0..11; the core uses constant {4'hF-r, r}.
- `perm_state_i` in 320: round core result, combinational from `perm_state_o` and `perm_round_o`.

Behaviour:
- Reset, asynchronous on `rst_n` low, from any state including mid-message:
  - FSM goes to IDLE; state register, key register and counters clear.
  - `ad_ready`, `pt_ready`, `ct_valid`, `done` and `busy` go to 0; `ct_data`, `tag` and `perm_round_o` go to 0.
  - No partial output is emitted after reset release.
- IDLE:
  - When `start`=1 and `pt_cnt`≠0, on that edge: load x0=`IV`, x1=k0, x2=k1, x3=n0, x4=n1; latch key and counts; go to INIT with r=0.
  - `start` with `pt_cnt`=0 is ignored.
- INIT: one round per edge, with `perm_round_o`=r for r=0..11 (p^12 starts at r=0; p^6 starts at r=6).
  - The final INIT round writes `perm_state_i` with x3^=k0 and x4^=k1.
  - If `ad_cnt`=0, that same write also applies x4^=1 (domain separation) and the FSM goes to PT_WAIT; otherwise it goes to AD_WAIT.
- AD_WAIT: `ad_ready`=1.
  - On `ad_valid`&&`ad_ready`: x0^=`ad_data`, decrement the AD count, go to AD_PERM with r=6.
- AD_PERM: runs rounds r=6..11.
  - The last round write applies x4^=1 if the block was the last AD block, then goes to PT_WAIT; otherwise it goes to AD_WAIT.
- PT_WAIT: `pt_ready`=1. On a handshake, the next cycle has `ct_valid`=1 and `ct_data`=x0^`pt_data`, and x0 takes that value.
  - Not the last block: go to PT_PERM with r=6, rounds 6..11, then back to PT_WAIT.
  - Last block: the same edge also applies x1^=k0 and x2^=k1, then go to FINAL with r=0.
- FINAL: rounds 0..11.
  - The last round edge loads `tag`={new x3^k0, new x4^k1}, sets `done`=1 for one cycle, and goes to IDLE.
  - `tag` holds its value until the next `start`.
- Round core contract: `perm_state_o` is the registered state and `perm_state_i` is taken combinationally; there is zero cycle bubble between rounds or between phases.
- `ready` behaviour:
  - `ready` is never asserted outside its WAIT state.
  - A `valid` held during PERM states is not consumed.
  - Data on `ad_valid`/`pt_valid` in other phases is ignored.
- `start` while busy is ignored. Counts use CNT_W-bit down counters, so they never wrap within a message.
- Latency with `valid` held high, start edge = 0:
  - Phase durations: INIT 12 edges; each AD block 1+6 edges; each non-last PT block 1+6 edges; last PT block 1+12 edges.
  - `done` rises after edge 12 + 7·ad_cnt + 7·(pt_cnt−1) + 13.

Test Plan:
- Reset/idle: hold `rst_n`=0 then release with no `start` -> all outputs 0, `busy`=0, `perm_round_o`=0.
- Full message:
  - Stimulus: key={C74F26B30A8C44B2 placed as k1, 265F1C12888E151A as k0}, nonce={369C801F3AE8D0EA, 9BF367D58FD211FF}, ad_cnt=3 with data 7895160/8882055/37008, pt_cnt=2 with pt=1234567890abcdef twice, valids always high.
  - Response: `ct_valid` pulses after edges 34 and 41; `done` is high after edge 53; ct and tag match the software golden model bit-exactly.
- No AD: ad_cnt=0, pt_cnt=1 -> `ad_ready` never asserts, x4 low bit is flipped at INIT end, `done` after edge 25, tag matches model.
- Backpressure: deassert `ad_valid` for 5 cycles in the middle of AD -> FSM waits in AD_WAIT, `perm_round_o` is frozen, `done` is delayed by exactly 5 cycles, tag is unchanged.
- Illegal start: `start` with pt_cnt=0 -> stays IDLE, `busy`=0. `start` pulsed during FINAL -> ignored and the tag is unaffected.
- Reset mid-operation: drop `rst_n` during AD_PERM round r=8 -> outputs clear immediately with no clock. A new start after release yields the same tag as a clean run.
